esfa_op_sequencer: RTL

- Command-level controller for a bank of NUM_CELLS ESFA memory cells, with cell i tied to handle i.
- Accepts one host command at a time and broadcasts the matching cell selector and operands to all cells.
- Waits out the cell output register, then priority-reduces the per-cell bool/result/context vectors into a single response.
- Sequences INSERT as two broadcasts: find a free cell, then update it.

---
 rtl/esfa_pkg.sv | 48 ++++
 rtl/esfa_priority_encoder.sv | 24 ++
 rtl/esfa_op_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA cell bank: cell selectors, host opcodes and sequencer states.
package esfa_pkg;

  localparam int unsigned HANDLE_W = 8;

  localparam logic [7:0] SEL_UPDATE    = 8'd0;
  localparam logic [7:0] SEL_LOOKUP    = 8'd1;
  localparam logic [7:0] SEL_ENCODE    = 8'd2;
  localparam logic [7:0] SEL_CONG_UP   = 8'd3;
  localparam logic [7:0] SEL_CONG_DOWN = 8'd4;
  localparam logic [7:0] SEL_FIND_FREE = 8'd5;
  localparam logic [7:0] SEL_ENRANK    = 8'd6;
  localparam logic [7:0] SEL_DEBUG     = 8'd7;
  localparam logic [7:0] SEL_NOP       = 8'hFF;

  localparam logic [2:0] OP_INSERT    = 3'd0;
  localparam logic [2:0] OP_LOOKUP    = 3'd1;
  localparam logic [2:0] OP_ENCODE    = 3'd2;
  localparam logic [2:0] OP_CONG_UP   = 3'd3;
  localparam logic [2:0] OP_CONG_DOWN = 3'd4;
  localparam logic [2:0] OP_ENRANK    = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StReduce,
    StResp
  } seq_state_e;

  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_INSERT) || (op == OP_CONG_UP) || (op == OP_CONG_DOWN);
  endfunction

  // INSERT uses two selectors: find a free cell first, then update it.
  function automatic logic [7:0] op_selector(input logic [2:0] op, input logic phase2);
    case (op)
      OP_INSERT:    return phase2 ? SEL_UPDATE : SEL_FIND_FREE;
      OP_LOOKUP:    return SEL_LOOKUP;
      OP_ENCODE:    return SEL_ENCODE;
      OP_CONG_UP:   return SEL_CONG_UP;
      OP_CONG_DOWN: return SEL_CONG_DOWN;
      OP_ENRANK:    return SEL_ENRANK;
      default:      return SEL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/esfa_priority_encoder.sv
// Combinational lowest-index-set finder over a request vector; also used by the host allocator.
module esfa_priority_encoder
  import esfa_pkg::*;
#(
  parameter int unsigned NUM_CELLS = 8
) (
  input  logic [NUM_CELLS-1:0] req,
  output logic                 found,
  output logic [HANDLE_W-1:0]  index
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = int'(NUM_CELLS) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = HANDLE_W'(i);
      end
    end
  end

endmodule

// File: rtl/esfa_op_sequencer.sv
// Command sequencer for a bank of ESFA cells: broadcast, settle, priority-reduce, respond.
// Optional statistics counters are built when ESFA_SEQ_STATS_EN is defined.
module esfa_op_sequencer
  import esfa_pkg::*;
#(
  parameter int unsigned NUM_CELLS    = 8,
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [7:0]             cmd_index,
  input  logic [7:0]             cmd_value,
  input  logic [7:0]             cmd_meta,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_hit,
  output logic [7:0]             rsp_handle,
  output logic [7:0]             rsp_value,
  output logic [7:0]             rsp_context,
  output logic                   rsp_err,
  output logic [7:0]             cell_selector,
  output logic [7:0]             cell_index,
  output logic [7:0]             cell_value,
  output logic [7:0]             cell_meta,
  output logic                   cell_is_meta,
  input  logic [NUM_CELLS-1:0]   cell_bool,
  input  logic [NUM_CELLS*8-1:0] cell_result,
  input  logic [NUM_CELLS*8-1:0] cell_context,
  output logic [15:0]            stat_cmds,
  output logic [15:0]            stat_misses
);

  localparam logic [2:0] SettleLoad = (CELL_LATENCY > 1) ? 3'(CELL_LATENCY - 2) : 3'd0;

  seq_state_e          state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [7:0]          index_q, index_d;
  logic [7:0]          value_q, value_d;
  logic [7:0]          meta_q, meta_d;
  logic                phase2_q, phase2_d;
  logic [HANDLE_W-1:0] handle_q, handle_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          rsp_handle_q, rsp_handle_d;
  logic [7:0]          rsp_value_q, rsp_value_d;
  logic [7:0]          rsp_context_q, rsp_context_d;

  logic                enc_found;
  logic [HANDLE_W-1:0] enc_index;
  logic [7:0]          win_result, win_context;

  esfa_priority_encoder #(
    .NUM_CELLS(NUM_CELLS)
  ) u_prio (
    .req  (cell_bool),
    .found(enc_found),
    .index(enc_index)
  );

  always_comb begin
    win_result  = '0;
    win_context = '0;
    for (int i = 0; i < int'(NUM_CELLS); i++) begin
      if (enc_index == HANDLE_W'(i)) begin
        win_result  = cell_result[8*i +: 8];
        win_context = cell_context[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    index_d       = index_q;
    value_d       = value_q;
    meta_d        = meta_q;
    phase2_d      = phase2_q;
    handle_d      = handle_q;
    cnt_d         = cnt_q;
    rsp_hit_d     = rsp_hit_q;
    rsp_err_d     = rsp_err_q;
    rsp_handle_d  = rsp_handle_q;
    rsp_value_d   = rsp_value_q;
    rsp_context_d = rsp_context_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          index_d  = cmd_index;
          value_d  = cmd_value;
          meta_d   = cmd_meta;
          phase2_d = 1'b0;
          if (cmd_op > OP_ENRANK) begin
            rsp_hit_d     = 1'b0;
            rsp_err_d     = 1'b1;
            rsp_handle_d  = '0;
            rsp_value_d   = '0;
            rsp_context_d = '0;
            state_d       = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (CELL_LATENCY > 1) begin
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end else begin
          state_d = StReduce;
        end
      end
      StSettle: begin
        if (cnt_q == 3'd0) begin
          state_d = StReduce;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StReduce: begin
        rsp_handle_d  = enc_index;
        rsp_value_d   = win_result;
        rsp_context_d = win_context;
        rsp_hit_d     = enc_found;
        rsp_err_d     = 1'b0;
        if (op_q == OP_INSERT && !phase2_q) begin
          if (enc_found) begin
            handle_d = enc_index;
            phase2_d = 1'b1;
            state_d  = StIssue;
          end else begin
            rsp_hit_d = 1'b0;
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end
        end else begin
          if (is_write_op(op_q)) rsp_hit_d = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      op_q          <= '0;
      index_q       <= '0;
      value_q       <= '0;
      meta_q        <= '0;
      phase2_q      <= 1'b0;
      handle_q      <= '0;
      cnt_q         <= '0;
      rsp_hit_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_handle_q  <= '0;
      rsp_value_q   <= '0;
      rsp_context_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      index_q       <= index_d;
      value_q       <= value_d;
      meta_q        <= meta_d;
      phase2_q      <= phase2_d;
      handle_q      <= handle_d;
      cnt_q         <= cnt_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_err_q     <= rsp_err_d;
      rsp_handle_q  <= rsp_handle_d;
      rsp_value_q   <= rsp_value_d;
      rsp_context_q <= rsp_context_d;
    end
  end

  // Selector is live only in ISSUE, so every broadcast is a single-cycle pulse.
  always_comb begin
    cell_selector = SEL_NOP;
    cell_index    = '0;
    cell_value    = '0;
    cell_meta     = '0;
    cell_is_meta  = 1'b0;
    if (state_q == StIssue) begin
      cell_selector = op_selector(op_q, phase2_q);
      cell_index    = index_q;
      cell_value    = value_q;
      cell_meta     = phase2_q ? handle_q : meta_q;
      cell_is_meta  = 1'b1;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_hit     = rsp_hit_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_handle  = rsp_handle_q;
  assign rsp_value   = rsp_value_q;
  assign rsp_context = rsp_context_q;

`ifdef ESFA_SEQ_STATS_EN
  logic        rsp_fire;
  logic [15:0] stat_cmds_q, stat_misses_q;

  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_cmds_q   <= '0;
      stat_misses_q <= '0;
    end else if (rsp_fire) begin
      if (stat_cmds_q != 16'hFFFF) stat_cmds_q <= stat_cmds_q + 16'd1;
      if (!rsp_hit_q && stat_misses_q != 16'hFFFF) stat_misses_q <= stat_misses_q + 16'd1;
    end
  end

  assign stat_cmds   = stat_cmds_q;
  assign stat_misses = stat_misses_q;
`else
  assign stat_cmds   = '0;
  assign stat_misses = '0;
`endif

endmodule
